// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: byte-serial controller that arbitrates an instruction-fetch
// port and a data-memory port onto one 8-bit single-port RAM.
// Optional feature macro: MCTRL_IF_ABORT_EN. When defined, an in-flight
// instruction fetch restarts from the new if_addr if if_addr moves away
// from the latched base.
module mem_ctrl_arb #(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4,
  parameter int RAM_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic                    if_req,
  input  logic [ADDR_W-1:0]       if_addr,
  output logic                    if_done,
  output logic [WORD_BYTES*8-1:0] if_data,
  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic [1:0]              mem_size,
  input  logic                    mem_signed,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [WORD_BYTES*8-1:0] mem_wdata,
  output logic                    mem_done,
  output logic [WORD_BYTES*8-1:0] mem_rdata,
  input  logic [7:0]              ram_din,
  output logic                    ram_wr,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [7:0]              ram_dout
);
  localparam int DW = WORD_BYTES*8;
  localparam int CW = $clog2(WORD_BYTES) + 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e              state_q;
  logic                last_mem_q;   // 1 = most recent grant went to MEM
  logic                own_mem_q;    // owner of the current transaction
  logic                sgn_q;
  logic [ADDR_W-1:0]   base_q;
  logic [CW-1:0]       n_q, iss_q, cap_q;
  logic [RAM_LAT:0]    vld_pipe_q;   // bit j set: a byte was issued j edges ago
  logic [DW-1:0]       buf_q, wdata_q;
  logic                if_done_q, mem_done_q, ram_wr_q;
  logic [DW-1:0]       if_data_q, mem_rdata_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [7:0]          ram_dout_q;

  logic [CW-1:0]       mem_n;
  logic                gnt_mem, gnt_if, sbit, abort;
  logic [DW-1:0]       fill, ext;
  logic [7:0]          wbyte;

  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_wr    = ram_wr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_dout  = ram_dout_q;

  // Arbitration, byte lane merge, load extension and write byte select
  always_comb begin
    case (mem_size)
      2'd0:    mem_n = CW'(1);
      2'd1:    mem_n = CW'(2);
      default: mem_n = CW'(WORD_BYTES);
    endcase
    // Round-robin on contention: MEM wins unless it had the last grant
    gnt_mem = mem_req && (!if_req || !last_mem_q);
    gnt_if  = if_req && !gnt_mem;
    fill    = buf_q;
    wbyte   = 8'h00;
    sbit    = 1'b0;
    ext     = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (CW'(k) == cap_q) fill[k*8 +: 8] = ram_din;
      if (CW'(k) == iss_q) wbyte = wdata_q[k*8 +: 8];
    end
    // Sign bit is the top bit of the last byte actually loaded
    for (int k = 0; k < WORD_BYTES; k++)
      if (CW'(k + 1) == n_q) sbit = fill[k*8 + 7];
    for (int k = 0; k < WORD_BYTES; k++)
      ext[k*8 +: 8] = (CW'(k) < n_q) ? fill[k*8 +: 8] : {8{sgn_q & sbit}};
`ifdef MCTRL_IF_ABORT_EN
    abort = (state_q == READ) && !own_mem_q && (if_addr != base_q);
`else
    abort = 1'b0;
`endif
  end

  // Main FSM with registered outputs; rdy low freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_mem_q  <= 1'b0;
      own_mem_q   <= 1'b0;
      sgn_q       <= 1'b0;
      base_q      <= '0;
      n_q         <= '0;
      iss_q       <= '0;
      cap_q       <= '0;
      vld_pipe_q  <= '0;
      buf_q       <= '0;
      wdata_q     <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      ram_wr_q    <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
    end else if (rdy) begin
      case (state_q)
        IDLE: begin
          if (gnt_mem || gnt_if) begin
            own_mem_q  <= gnt_mem;
            last_mem_q <= gnt_mem;
            sgn_q      <= gnt_mem && mem_signed;
            base_q     <= gnt_mem ? mem_addr : if_addr;
            n_q        <= gnt_mem ? mem_n : CW'(WORD_BYTES);
            wdata_q    <= mem_wdata;
            ram_addr_q <= gnt_mem ? mem_addr : if_addr;
            iss_q      <= CW'(1);
            cap_q      <= '0;
            vld_pipe_q <= {{RAM_LAT{1'b0}}, 1'b1};
            if (gnt_mem && mem_we) begin
              ram_wr_q   <= 1'b1;
              ram_dout_q <= mem_wdata[7:0];
              state_q    <= WRITE;
            end else begin
              state_q    <= READ;
            end
          end
        end
        READ: begin
          if (abort) begin
            // Fetch target moved: drop in-flight bytes and restart
            base_q     <= if_addr;
            ram_addr_q <= if_addr;
            iss_q      <= CW'(1);
            cap_q      <= '0;
            vld_pipe_q <= {{RAM_LAT{1'b0}}, 1'b1};
          end else begin
            vld_pipe_q <= {vld_pipe_q[RAM_LAT-1:0], iss_q < n_q};
            if (iss_q < n_q) begin
              ram_addr_q <= base_q + ADDR_W'(iss_q);
              iss_q      <= iss_q + CW'(1);
            end else begin
              ram_addr_q <= '0;
            end
            if (vld_pipe_q[RAM_LAT]) begin
              buf_q <= fill;
              cap_q <= cap_q + CW'(1);
              if (cap_q == n_q - CW'(1)) begin
                state_q <= DONE;
                if (own_mem_q) begin
                  mem_rdata_q <= ext;
                  mem_done_q  <= 1'b1;
                end else begin
                  if_data_q   <= ext;
                  if_done_q   <= 1'b1;
                end
              end
            end
          end
        end
        WRITE: begin
          if (iss_q < n_q) begin
            ram_addr_q <= base_q + ADDR_W'(iss_q);
            ram_dout_q <= wbyte;
            iss_q      <= iss_q + CW'(1);
          end else begin
            ram_wr_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_dout_q <= '0;
            mem_done_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        default: begin
          if_done_q  <= 1'b0;
          mem_done_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end
endmodule
